msrv32_pc_branch_ctrl: RTL and testbench
========================================

// Module: msrv32_pc_branch_ctrl
// PURPOSE
//  Sequences the program counter around the branch unit's decision: computes the branch/jump target,
//  drives the instruction-memory fetch handshake, and issues one-cycle pipeline flushes on redirect.
//  Sits between decode/branch unit and IMEM; consumes branch_taken and owns pc_out / imem_addr_out.
// PARAMETERS
//  WIDTH      32            datapath/address width
//  BOOT_ADDR  32'h0000_0000 pc_out value during and after reset
// PORTS
//  ms_riscv32_mp_clk_in   in  1      single clock, all state on rising edge
//  ms_riscv32_mp_rst_in   in  1      reset, synchronous, active-low
//  opcode_in              in  5      instr[6:2] of instruction at pc_out
//  funct3_in              in  3      instr[14:12]
//  imm_in                 in  WIDTH  sign-extended immediate (B/J/I type)
//  rs1_in                 in  WIDTH  rs1 value (JALR base)
//  branch_taken_in        in  1      branch unit decision for current instruction
//  instr_valid_in         in  1      instruction at pc_out is valid this cycle
//  stall_in               in  1      downstream hold; freezes PC and decision
//  imem_ready_in          in  1      IMEM accepts/returns the requested fetch
//  trap_vec_in            in  WIDTH  misaligned-target trap vector
//  imem_req_out           out 1      fetch request
//  imem_addr_out          out WIDTH  fetch address; stable while req && !ready
//  pc_out                 out WIDTH  PC of instruction in execute
//  pc_plus4_out           out WIDTH  pc_out + 4 (link value), mod 2^WIDTH
//  flush_out              out 1      one-cycle flush of fetched instruction
//  misaligned_instr_out   out 1      one-cycle pulse, misaligned taken target
// BEHAVIOUR
//  Reset (rst_in==0 at edge): state=BOOT, pc_out=imem_addr_out=BOOT_ADDR, imem_req_out=0,
//   flush_out=0, misaligned_instr_out=0; overrides everything incl. in-flight fetch (fetch dropped).
//  States: BOOT -> FETCH (first cycle out of reset, req=1 addr=BOOT_ADDR);
//   FETCH: req=1; stays until imem_ready_in; then -> RUN. RUN: evaluates instructions.
//   REDIRECT: one cycle, flush_out=1, req=1 addr=target; -> FETCH (or RUN if ready that cycle).
//   TRAP (macro only): like REDIRECT but addr=trap_vec_in, misaligned_instr_out=1.
//  Decision taken in RUN only when instr_valid_in && !stall_in; else PC/state hold.
//  Redirect condition: opcode 5'b11011 (JAL), 5'b11001 with funct3 3'b000 (JALR), or
//   opcode 5'b11000 with branch_taken_in==1. Otherwise sequential: next PC = pc_out+4.
//  Target: JAL/branch = pc_out+imm_in; JALR = (rs1_in+imm_in) & ~1; all adds wrap mod 2^WIDTH.
//  Latency: decision in cycle N -> pc_out/imem_addr_out = target at N+1, flush_out=1 in N+1 only.
//  Sequential advance needs imem_ready_in; if !ready, PC holds and addr stays stable (no change
//   while req && !ready). Redirect while IMEM busy: target latched, applied when ready; flush
//   still issued at N+1; only most recent target retained.
//  stall_in and redirect same cycle: stall wins; decision re-evaluated when stall drops.
//  Back-to-back redirects: instruction in REDIRECT cycle is flushed and never evaluated.
//  Unknown opcodes / branch funct3 010/011: no redirect (branch_taken_in ignored if opcode not 11000).
// CONFIGURATION
//  MSRV32_MISALIGN_TRAP_EN defined: redirect with target[1:0]!=0 -> TRAP state; fetch from
//   trap_vec_in, misaligned_instr_out=1 for exactly one cycle coincident with flush_out.
//  Undefined: target[1:0] forced to 2'b00, no TRAP state, misaligned_instr_out tied 0.
// TESTING
//  Reset release, imem_ready_in=1 -> req at BOOT_ADDR cycle 1, pc_out advances +4 per valid instr.
//  pc=0x100, BEQ imm=0x20, taken=1 -> next cycle pc_out=0x120, flush_out=1 one cycle.
//  JALR rs1=0x2003 imm=4 -> target 0x2006; macro on: pc=trap_vec_in, misaligned pulse;
//   macro off: pc=0x2004, no pulse.
//  JAL imm=-8 at pc=0x4 -> pc_out=0xFFFF_FFFC (wrap); pc_plus4_out was 0x8.
//  Taken branch with imem_ready_in=0 for 3 cycles -> addr stable, target fetched on ready,
//   single flush pulse; stall_in=1 same cycle as taken -> no redirect until stall drops.
//  Reset asserted mid-FETCH -> next cycle pc_out=BOOT_ADDR, req=0, flush=0, misaligned=0.

Source files
------------

// File: rtl/msrv32_pc_branch_ctrl.sv
// PC sequencer around the branch decision: target calc, IMEM fetch handshake, flushes.
// Ports: clk/rst (sync, active-low), decode fields + branch_taken in; imem req/addr, pc, pc+4,
//   flush and misaligned pulse out. Optional MSRV32_MISALIGN_TRAP_EN adds the TRAP state.
module msrv32_pc_branch_ctrl #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] BOOT_ADDR = '0
) (
   input  logic             ms_riscv32_mp_clk_in,
   input  logic             ms_riscv32_mp_rst_in,
   input  logic [4:0]       opcode_in,
   input  logic [2:0]       funct3_in,
   input  logic [WIDTH-1:0] imm_in,
   input  logic [WIDTH-1:0] rs1_in,
   input  logic             branch_taken_in,
   input  logic             instr_valid_in,
   input  logic             stall_in,
   input  logic             imem_ready_in,
   input  logic [WIDTH-1:0] trap_vec_in,
   output logic             imem_req_out,
   output logic [WIDTH-1:0] imem_addr_out,
   output logic [WIDTH-1:0] pc_out,
   output logic [WIDTH-1:0] pc_plus4_out,
   output logic             flush_out,
   output logic             misaligned_instr_out
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_FETCH,
      S_RUN,
`ifdef MSRV32_MISALIGN_TRAP_EN
      S_REDIR,
      S_TRAP
`else
      S_REDIR
`endif
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             pend_q, pend_d;

   logic             is_jal, is_jalr, is_br, redir, mis;
   logic [WIDTH-1:0] raw_tgt, dest, seq_pc;

   assign seq_pc = pc_q + WIDTH'(4);

   always_ff @(posedge ms_riscv32_mp_clk_in) begin
      if (!ms_riscv32_mp_rst_in) begin
         state_q <= S_BOOT;
         pc_q    <= BOOT_ADDR;
         addr_q  <= BOOT_ADDR;
         tgt_q   <= BOOT_ADDR;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         addr_q  <= addr_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      is_jal  = (opcode_in == 5'b11011);
      is_jalr = (opcode_in == 5'b11001) && (funct3_in == 3'b000);
      is_br   = (opcode_in == 5'b11000) && branch_taken_in &&
                (funct3_in != 3'b010) && (funct3_in != 3'b011);
      redir   = is_jal | is_jalr | is_br;
      raw_tgt = is_jalr ? ((rs1_in + imm_in) & ~WIDTH'(1))
                        : (pc_q + imm_in);
`ifdef MSRV32_MISALIGN_TRAP_EN
      mis  = (raw_tgt[1:0] != 2'b00);
      dest = mis ? trap_vec_in : raw_tgt;
`else
      mis  = 1'b0;
      dest = {raw_tgt[WIDTH-1:2], 2'b00};
`endif
   end

   // A fetch in flight can't have its address changed, so a redirect
   // taken while IMEM is busy parks the destination in tgt_q until ready.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      addr_d  = addr_q;
      tgt_d   = tgt_q;
      pend_d  = pend_q;
      unique case (state_q)
         S_BOOT: begin
            state_d = S_FETCH;
            pc_d    = BOOT_ADDR;
            addr_d  = BOOT_ADDR;
            pend_d  = 1'b0;
         end
         S_FETCH: begin
            if (imem_ready_in) begin
               if (pend_q) begin
                  addr_d = tgt_q;
                  pend_d = 1'b0;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (instr_valid_in && !stall_in) begin
               if (redir) begin
                  pc_d = dest;
`ifdef MSRV32_MISALIGN_TRAP_EN
                  state_d = mis ? S_TRAP : S_REDIR;
`else
                  state_d = S_REDIR;
`endif
                  if (imem_ready_in) begin
                     addr_d = dest;
                  end else begin
                     pend_d = 1'b1;
                     tgt_d  = dest;
                  end
               end else if (imem_ready_in) begin
                  pc_d   = seq_pc;
                  addr_d = seq_pc;
               end
            end
         end
         default: begin
            // REDIR / TRAP: always a single cycle
            if (pend_q) begin
               state_d = S_FETCH;
               if (imem_ready_in) begin
                  addr_d = tgt_q;
                  pend_d = 1'b0;
               end
            end else begin
               state_d = imem_ready_in ? S_RUN : S_FETCH;
            end
         end
      endcase
   end

   always_comb begin
      imem_req_out  = (state_q != S_BOOT);
      imem_addr_out = addr_q;
      pc_out        = pc_q;
      pc_plus4_out  = seq_pc;
`ifdef MSRV32_MISALIGN_TRAP_EN
      flush_out            = (state_q == S_REDIR) || (state_q == S_TRAP);
      misaligned_instr_out = (state_q == S_TRAP);
`else
      flush_out            = (state_q == S_REDIR);
      misaligned_instr_out = 1'b0;
`endif
   end

endmodule

// File: tb/tb_msrv32_pc_branch_ctrl.sv
// Directed bench for msrv32_pc_branch_ctrl.
// Works with or without MSRV32_MISALIGN_TRAP_EN.
module tb_msrv32_pc_branch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm, rs1, trap_vec;
   logic        taken, valid, stall, ready;
   logic        req, flush, mis;
   logic [31:0] addr, pc, pc4;

   int n_chk = 0;
   int n_fail = 0;

   localparam logic [4:0] OP_NOP  = 5'b00100;
   localparam logic [4:0] OP_JAL  = 5'b11011;
   localparam logic [4:0] OP_JALR = 5'b11001;
   localparam logic [4:0] OP_BR   = 5'b11000;
   localparam logic [31:0] TVEC = 32'h0000_0800;
`ifdef MSRV32_MISALIGN_TRAP_EN
   localparam logic [31:0] P = TVEC;
   localparam logic        MIS_EXP = 1'b1;
`else
   localparam logic [31:0] P = 32'h0000_2004;
   localparam logic        MIS_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   msrv32_pc_branch_ctrl dut (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst_n),
      .opcode_in            (opcode),
      .funct3_in            (funct3),
      .imm_in               (imm),
      .rs1_in               (rs1),
      .branch_taken_in      (taken),
      .instr_valid_in       (valid),
      .stall_in             (stall),
      .imem_ready_in        (ready),
      .trap_vec_in          (trap_vec),
      .imem_req_out         (req),
      .imem_addr_out        (addr),
      .pc_out               (pc),
      .pc_plus4_out         (pc4),
      .flush_out            (flush),
      .misaligned_instr_out (mis)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [4:0] op, input logic [2:0] f3,
                        input logic [31:0] im, input logic tk);
      opcode = op; funct3 = f3; imm = im; taken = tk; valid = 1'b1;
   endtask

   task automatic idle();
      opcode = OP_NOP; funct3 = 3'b000; imm = '0; taken = 1'b0; valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rs1 = '0; trap_vec = TVEC; stall = 1'b0; ready = 1'b1;
      idle();

      // reset state
      step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_req", {31'b0, req}, 32'h0);
      chk("rst_flush", {31'b0, flush}, 32'h0);
      chk("rst_mis", {31'b0, mis}, 32'h0);

      // boot fetch
      rst_n = 1'b1;
      step();
      chk("boot_req", {31'b0, req}, 32'h1);
      chk("boot_addr", addr, 32'h0);
      step();
      chk("run_pc", pc, 32'h0);

      // sequential advance
      instr(OP_NOP, 3'b000, 32'h0, 1'b0);
      step();
      chk("seq_pc", pc, 32'h4);
      chk("seq_addr", addr, 32'h4);
      chk("seq_flush", {31'b0, flush}, 32'h0);
      chk("seq_pc4", pc4, 32'h8);

      // JAL wrap
      instr(OP_JAL, 3'b000, 32'hFFFF_FFF8, 1'b0);
      step();
      chk("jal_wrap_pc", pc, 32'hFFFF_FFFC);
      chk("jal_wrap_addr", addr, 32'hFFFF_FFFC);
      chk("jal_flush", {31'b0, flush}, 32'h1);
      chk("jal_pc4_wrap", pc4, 32'h0);
      idle();
      step();
      chk("jal_flush_end", {31'b0, flush}, 32'h0);

      // JAL to 0x100
      instr(OP_JAL, 3'b000, 32'h0000_0104, 1'b0);
      step();
      chk("jal100_pc", pc, 32'h100);
      idle();
      step();

      // BEQ taken
      instr(OP_BR, 3'b000, 32'h20, 1'b1);
      step();
      chk("beq_pc", pc, 32'h120);
      chk("beq_addr", addr, 32'h120);
      chk("beq_flush", {31'b0, flush}, 32'h1);
      idle();
      step();
      chk("beq_flush_end", {31'b0, flush}, 32'h0);

      // reserved branch funct3 ignores taken
      instr(OP_BR, 3'b010, 32'h20, 1'b1);
      step();
      chk("br010_pc", pc, 32'h124);
      chk("br010_flush", {31'b0, flush}, 32'h0);

      // branch not taken
      instr(OP_BR, 3'b000, 32'h20, 1'b0);
      step();
      chk("bnt_pc", pc, 32'h128);

      // taken flag on non-branch opcode
      instr(OP_NOP, 3'b000, 32'h40, 1'b1);
      step();
      chk("nonbr_taken_pc", pc, 32'h12C);

      // JALR misaligned target 0x2006
      rs1 = 32'h0000_2003;
      instr(OP_JALR, 3'b000, 32'h4, 1'b0);
      step();
      chk("jalr_pc", pc, P);
      chk("jalr_addr", addr, P);
      chk("jalr_flush", {31'b0, flush}, 32'h1);
      chk("jalr_mis", {31'b0, mis}, {31'b0, MIS_EXP});
      idle();
      step();
      chk("jalr_mis_end", {31'b0, mis}, 32'h0);
      chk("jalr_flush_end", {31'b0, flush}, 32'h0);

      // taken branch while IMEM busy for 3 cycles
      ready = 1'b0;
      instr(OP_BR, 3'b001, 32'h40, 1'b1);
      step();
      chk("busy_pc", pc, P + 32'h40);
      chk("busy_addr0", addr, P);
      chk("busy_flush", {31'b0, flush}, 32'h1);
      idle();
      step();
      chk("busy_addr1", addr, P);
      chk("busy_flush1", {31'b0, flush}, 32'h0);
      step();
      chk("busy_addr2", addr, P);
      ready = 1'b1;
      step();
      chk("busy_tgt_addr", addr, P + 32'h40);
      chk("busy_flush3", {31'b0, flush}, 32'h0);
      step();
      chk("busy_flush4", {31'b0, flush}, 32'h0);
      chk("busy_req", {31'b0, req}, 32'h1);

      // stall wins over redirect
      stall = 1'b1;
      instr(OP_JAL, 3'b000, 32'h10, 1'b0);
      step();
      chk("stall_pc", pc, P + 32'h40);
      chk("stall_flush", {31'b0, flush}, 32'h0);
      step();
      chk("stall_pc2", pc, P + 32'h40);
      stall = 1'b0;
      step();
      chk("unstall_pc", pc, P + 32'h50);
      chk("unstall_flush", {31'b0, flush}, 32'h1);
      idle();
      step();

      // reset mid-FETCH
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      ready = 1'b0;
      step();
      chk("fetch_req", {31'b0, req}, 32'h1);
      step();
      rst_n = 1'b0;
      step();
      chk("mrst_pc", pc, 32'h0);
      chk("mrst_req", {31'b0, req}, 32'h0);
      chk("mrst_flush", {31'b0, flush}, 32'h0);
      chk("mrst_mis", {31'b0, mis}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
